count_display_scan: RTL and testbench

Downstream consumer of the 4-bit `counter` output. Converts the unsigned count (0–15) into two decimal digits and time-multiplexes them onto a two-digit, common-anode seven-segment display. The block samples `count` only at frame boundaries, so both digits always show the same value. It blanks the tens digit when it is zero and inserts a one-cycle all-off guard at every digit switch to suppress ghosting.

---
 rtl/count_display_scan.sv | 88 ++++++++
 tb/tb_count_display_scan.sv | 130 +++++++++++++
 2 files changed

// File: rtl/count_display_scan.sv
// Two-digit common-anode seven-segment scanner for a 4-bit count (0-15).
// Captures count once per frame and inserts an all-off guard cycle at every digit switch.
module count_display_scan #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } digit_t;

  logic [PW-1:0] prescale;
  digit_t        digit_sel;
  logic [3:0]    shown_val;

  logic          tick;
  logic          tens;
  logic [3:0]    ones;
  logic [3:0]    digit;
  logic [6:0]    lit_seg;
  logic [1:0]    lit_an;

  assign tick = (prescale == PW'(REFRESH_DIV - 1));
  assign tens = (shown_val >= 4'd10);
  assign ones = tens ? (shown_val - 4'd10) : shown_val;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  // Output pattern for a lit (non-guard) cycle of the currently selected digit.
  always_comb begin
    lit_an = 2'b10;
    digit  = ones;
    if (digit_sel == DIG_TENS) begin
      lit_an = 2'b01;
      digit  = {3'b000, tens};
    end
    lit_seg = enc(digit);
    if (digit_sel == DIG_TENS && !tens && BLANK_LEADING) begin
      lit_an  = '1;
      lit_seg = '1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale  <= '0;
      digit_sel <= DIG_ONES;
      shown_val <= '0;
      an        <= '1;
      seg       <= '1;
    end else if (tick) begin
      prescale  <= '0;
      digit_sel <= (digit_sel == DIG_ONES) ? DIG_TENS : DIG_ONES;
      if (digit_sel == DIG_TENS)
        shown_val <= count;
      an        <= '1;
      seg       <= '1;
    end else begin
      prescale  <= prescale + PW'(1);
      an        <= lit_an;
      seg       <= lit_seg;
    end
  end

endmodule

// File: tb/tb_count_display_scan.sv
// Randomized bench for count_display_scan: two instances (leading zero blanked / shown)
// compared every cycle against a slot/frame arithmetic model of the display.
module tb_count_display_scan;

  localparam int unsigned R = 4;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic [6:0] seg_b, seg_z;
  logic [1:0] an_b, an_z;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned n        = 0;
  int unsigned shown    = 0;

  logic [6:0] enc_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  count_display_scan #(.REFRESH_DIV(R), .BLANK_LEADING(1'b1)) u_blank (
    .clk(clk), .reset(reset), .count(count), .seg(seg_b), .an(an_b)
  );

  count_display_scan #(.REFRESH_DIV(R), .BLANK_LEADING(1'b0)) u_zero (
    .clk(clk), .reset(reset), .count(count), .seg(seg_z), .an(an_z)
  );

  initial begin
    clk = 1'b1;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  // Expected {an,seg} after rising edge number edge_n (1-based since reset release).
  function automatic logic [8:0] expect_out(input int unsigned edge_n, input int unsigned v,
                                            input bit blank);
    int unsigned pos, slot;
    pos  = (edge_n - 1) % R;
    slot = ((edge_n - 1) / R) % 2;
    if (pos == R - 1)            return {2'b11, 7'h7F};
    if (slot == 0)               return {2'b10, enc_tab[v % 10]};
    if (v / 10 == 0 && blank)    return {2'b11, 7'h7F};
    return {2'b01, enc_tab[v / 10]};
  endfunction

  function automatic bit in_tens_lit(input int unsigned edge_n);
    return (((edge_n - 1) / R) % 2 == 1) && (((edge_n - 1) % R) < R - 2);
  endfunction

  task automatic step(input string tag);
    int unsigned sampled;
    sampled = count;
    @(posedge clk);
    n++;
    #1;
    check({tag, "_blank"}, {7'b0, an_b, seg_b}, {7'b0, expect_out(n, shown, 1'b1)});
    check({tag, "_zero"},  {7'b0, an_z, seg_z}, {7'b0, expect_out(n, shown, 1'b0)});
    if (((n - 1) % R == R - 1) && (((n - 1) / R) % 2 == 1))
      shown = sampled;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_blank"}, {7'b0, an_b, seg_b}, {7'b0, 2'b11, 7'h7F});
    check({tag, "_zero"},  {7'b0, an_z, seg_z}, {7'b0, 2'b11, 7'h7F});
  endtask

  initial begin
    reset = 1'b0;
    count = 4'd7;
    #5  check_off("rst_hold0");
    #10 check_off("rst_hold1");
    #10 check_off("rst_hold2");
    #5  reset = 1'b1;

    repeat (12) step("single7");

    count = 4'd13;
    repeat (20) step("two13");

    count = 4'd9;
    repeat (16) step("nine");
    for (int i = 0; i < 16; i++) begin
      if (shown == 9 && in_tens_lit(n + 1)) break;
      step("nine_wait");
    end
    count = 4'd15;
    repeat (16) step("fifteen");
    count = 4'd0;
    repeat (16) step("zero");

    repeat (300) begin
      if ($urandom_range(0, 4) == 0) count = 4'($urandom_range(0, 15));
      step("rand");
    end

    count = 4'd12;
    for (int i = 0; i < 40; i++) begin
      step("pre_rst");
      if (shown == 12 && in_tens_lit(n)) break;
    end
    check("pre_rst_shown12", 16'(shown), 16'd12);
    #2 reset = 1'b0;
    #1 check_off("async_rst");
    @(negedge clk);
    check_off("rst_mid0");
    @(posedge clk);
    #1 check_off("rst_mid1");
    @(negedge clk);
    reset = 1'b1;
    n     = 0;
    shown = 0;
    count = 4'($urandom_range(0, 15));
    repeat (60) begin
      if ($urandom_range(0, 3) == 0) count = 4'($urandom_range(0, 15));
      step("post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
